// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED driver.
package led_pkg;

    // Per-channel operating mode, encoded as the 2-bit MODE field.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } led_mode_t;

endpackage

// File: rtl/led_channel.sv
// One LED output register: selects OFF / ON / BLINK / PWM drive each clock.
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                blink_q,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                invert,
    output logic                led
);

    logic led_q, led_d;

    // Next LED value from the pre-edge mode, duty, blink phase and PWM count.
    always_comb begin
        led_d = 1'b0;
        case (led_mode_t'(mode))
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = blink_q ^ invert;
            MODE_PWM:   led_d = (pwm_cnt < duty);
            default:    led_d = 1'b0;
        endcase
    end

    // Output register; cleared immediately on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/multi_led_driver.sv
// Multi-channel LED driver: shared prescaler, blink phase and PWM counter
// feeding NUM_LEDS independently configured output channels.
module multi_led_driver
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned CLK_DIV  = 22,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [2*NUM_LEDS-1:0]        MODE,
    input  logic [PWM_BITS*NUM_LEDS-1:0] DUTY,
    input  logic                         SYNC,
    output logic [NUM_LEDS-1:0]          LED,
    output logic                         TICK
);

    logic [CLK_DIV-1:0]  presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                blink_q, blink_d;
    logic                tick_q, tick_d;
    logic                wrap;

    assign wrap = &presc_q;

    // Free-running counters; SYNC restarts every shared phase and masks a wrap.
    always_comb begin
        presc_d = presc_q + 1'b1;
        pwm_d   = pwm_q + 1'b1;
        blink_d = blink_q ^ wrap;
        tick_d  = wrap;
        if (SYNC) begin
            presc_d = '0;
            pwm_d   = '0;
            blink_d = 1'b0;
            tick_d  = 1'b0;
        end
    end

    // Shared timing state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q <= '0;
            pwm_q   <= '0;
            blink_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            blink_q <= blink_d;
            tick_q  <= tick_d;
        end
    end

    assign TICK = tick_q;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        localparam logic INV = (i % 2) == 1;

        led_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .mode    (MODE[2*i +: 2]),
            .duty    (DUTY[PWM_BITS*i +: PWM_BITS]),
            .blink_q (blink_q),
            .pwm_cnt (pwm_q),
            .invert  (INV),
            .led     (LED[i])
        );
    end

endmodule

// File: tb/tb_multi_led_driver.sv
// Bench for multi_led_driver: an edges-since-restart model checked every cycle,
// plus literal expectations on a 4-channel and a 1-channel instance.
module tb_multi_led_driver;

    localparam int unsigned NL = 4;
    localparam int unsigned CD = 3;
    localparam int unsigned PB = 4;

    logic            CLK;
    logic            RST_N;
    logic [2*NL-1:0] MODE;
    logic [PB*NL-1:0] DUTY;
    logic            SYNC;
    logic [NL-1:0]   LED;
    logic            TICK;

    logic            RST1_N;
    logic [1:0]      MODE1;
    logic [PB-1:0]   DUTY1;
    logic            SYNC1;
    logic [0:0]      LED1;
    logic            TICK1;

    int vectors     = 0;
    int miscompares = 0;
    logic check_en  = 1'b0;
    logic done1     = 1'b0;

    multi_led_driver #(.NUM_LEDS(NL), .CLK_DIV(CD), .PWM_BITS(PB)) dut (
        .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .DUTY(DUTY),
        .SYNC(SYNC), .LED(LED), .TICK(TICK)
    );

    multi_led_driver #(.NUM_LEDS(1), .CLK_DIV(6), .PWM_BITS(PB)) dut1 (
        .CLK(CLK), .RST_N(RST1_N), .MODE(MODE1), .DUTY(DUTY1),
        .SYNC(SYNC1), .LED(LED1), .TICK(TICK1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: n = edges since last restart (reset release or SYNC edge).
    int unsigned n;
    logic [NL-1:0] exp_led;
    logic          exp_tick;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            n        <= 0;
            exp_led  <= '0;
            exp_tick <= 1'b0;
        end else begin : model_step
            logic [NL-1:0] l;
            int unsigned   nn;
            for (int unsigned i = 0; i < NL; i++) begin
                case (MODE[2*i +: 2])
                    2'd0:    l[i] = 1'b0;
                    2'd1:    l[i] = 1'b1;
                    2'd2:    l[i] = (((n / (1 << CD)) % 2) == 1) ^ ((i % 2) == 1);
                    default: l[i] = (n % (1 << PB)) < DUTY[PB*i +: PB];
                endcase
            end
            nn = SYNC ? 0 : n + 1;
            n        <= nn;
            exp_led  <= l;
            exp_tick <= !SYNC && (nn % (1 << CD) == 0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (check_en) begin
            vectors++;
            if (LED !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t LED=%b want %b TICK=%b want %b",
                         $time, LED, exp_led, TICK, exp_tick);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_mode(input int unsigned c, input logic [1:0] m);
        MODE[2*c +: 2] = m;
    endtask

    // Single-LED legacy instance: CLK_DIV=6, BLINK.
    initial begin
        RST1_N = 1'b0;
        MODE1  = 2'd2;
        DUTY1  = '0;
        SYNC1  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("legacy_reset_led", 32'(LED1), 32'd0);
        RST1_N = 1'b1;
        for (int unsigned k = 1; k <= 130; k++) begin
            @(negedge CLK);
            if (k == 1 || k == 64 || k == 65 || k == 128 || k == 129) begin
                chk("legacy_led", 32'(LED1), (k >= 65 && k <= 128) ? 32'd1 : 32'd0);
                chk("legacy_tick", 32'(TICK1), (k == 64 || k == 128) ? 32'd1 : 32'd0);
            end
        end
        done1 = 1'b1;
    end

    int hi_cnt;
    int waited;

    initial begin
        RST_N = 1'b0;
        MODE  = {NL{2'd2}};
        DUTY  = '0;
        SYNC  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_led", 32'(LED), 32'd0);
        chk("reset_tick", 32'(TICK), 32'd0);
        check_en = 1'b1;
        RST_N    = 1'b1;

        // Blink phase and first TICK.
        for (int unsigned k = 1; k <= 17; k++) begin
            @(negedge CLK);
            if (k <= 8)
                chk("blink_led_early", 32'(LED), 32'b1010);
            if (k == 9)
                chk("blink_led_toggled", 32'(LED), 32'b0101);
            if (k == 17)
                chk("blink_led_back", 32'(LED), 32'b1010);
            chk("blink_tick", 32'(TICK), (k == 8 || k == 16) ? 32'd1 : 32'd0);
        end

        // PWM duty on channel 0.
        set_mode(0, 2'd3);
        DUTY[0 +: PB] = 4'd5;
        @(negedge CLK);
        hi_cnt = 0;
        repeat (64) begin @(negedge CLK); hi_cnt += int'(LED[0]); end
        chk("pwm_duty5", 32'(hi_cnt), 32'd20);

        DUTY[0 +: PB] = 4'd0;
        @(negedge CLK);
        hi_cnt = 0;
        repeat (64) begin @(negedge CLK); hi_cnt += int'(LED[0]); end
        chk("pwm_duty0", 32'(hi_cnt), 32'd0);

        DUTY[0 +: PB] = 4'd15;
        @(negedge CLK);
        hi_cnt = 0;
        repeat (64) begin @(negedge CLK); hi_cnt += int'(LED[0]); end
        chk("pwm_duty15", 32'(hi_cnt), 32'd60);

        // OFF then ON on channel 2: one edge of latency.
        repeat (3) @(negedge CLK);
        set_mode(2, 2'd0);
        @(negedge CLK);
        chk("ch2_off", 32'(LED[2]), 32'd0);
        set_mode(2, 2'd1);
        #1 chk("ch2_on_before_edge", 32'(LED[2]), 32'd0);
        @(negedge CLK);
        chk("ch2_on", 32'(LED[2]), 32'd1);
        repeat (5) @(negedge CLK);

        // SYNC at a wrap edge.
        MODE   = {NL{2'd2}};
        waited = 0;
        while ((n % 8) != 7 && waited < 16) begin
            @(negedge CLK);
            waited++;
        end
        chk("sync_align", 32'(n % 8), 32'd7);
        SYNC = 1'b1;
        @(negedge CLK);
        SYNC = 1'b0;
        chk("sync_tick_suppressed", 32'(TICK), 32'd0);
        for (int unsigned k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1)
                chk("sync_blink_led", 32'(LED), 32'b1010);
            chk("sync_next_tick", 32'(TICK), (k == 8) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset mid-cycle during blink.
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_led", 32'(LED), 32'd0);
        chk("async_rst_tick", 32'(TICK), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int unsigned k = 1; k <= 8; k++) begin
            @(negedge CLK);
            chk("rst_restart_tick", 32'(TICK), (k == 8) ? 32'd1 : 32'd0);
        end

        waited = 0;
        while (!done1 && waited < 1000) begin
            @(negedge CLK);
            waited++;
        end
        chk("legacy_done", 32'(done1), 32'd1);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
